// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed seven-segment driver.
// Glyphs are active-high {a,b,c,d,e,f,g}.
package hex_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [15:0][6:0] GLYPHS = {
    7'h47, 7'h4F, 7'h3D, 7'h4E,
    7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33,
    7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] nibble_to_seg(
    input logic [3:0] nib
  );
    return GLYPHS[nib];
  endfunction

endpackage

// File: rtl/hex_display_mux_refresh_divider.sv
// Digit-slot prescaler: counts 0..DIV-1 while enabled.
// slot_end marks the last cycle of each slot.
module refresh_divider #(
  parameter int DIV = 50000,
  parameter int CW  = $clog2(DIV)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          slot_end
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  assign slot_end = enable && (count == LAST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count <= '0;
    end else if (enable) begin
      count <= slot_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/hex_display_mux.sv
// Parametrised multiplexed seven-segment driver with
// frame snapshot, zero blanking, PWM dimming and polarity.
module hex_display_mux
  import hex_display_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int DIV              = 50000,
  parameter int BRIGHT_W         = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_lz,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [DIGITS-1:0]     anodes,
  output logic [6:0]            segments,
  output logic                  seg_dp,
  output logic                  frame_tick
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(DIV);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PWM_MAX =
    BRIGHT_W'((1 << BRIGHT_W) - 2);
  localparam logic AN_POL  = (ANODE_ACTIVE_LOW != 0);
  localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_INV = {DIGITS{AN_POL}};
  localparam logic [6:0] SEG_INV = {7{SEG_POL}};

  logic [CW-1:0]       count;
  logic                slot_end;
  logic [IW-1:0]       idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [4*DIGITS-1:0] snap_data;
  logic [DIGITS-1:0]   snap_dp;
  logic                snap_lz;
  logic                loaded;
  logic                frame_end;
  logic                load;

  refresh_divider #(
    .DIV (DIV),
    .CW  (CW)
  ) u_div (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .enable   (enable),
    .count    (count),
    .slot_end (slot_end)
  );

  assign frame_end = slot_end && (idx == LAST);
  assign load      = frame_end || (enable && !loaded);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx       <= '0;
      pwm_cnt   <= '0;
      snap_data <= '0;
      snap_dp   <= '0;
      snap_lz   <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      if (slot_end)
        idx <= (idx == LAST) ? '0 : idx + 1'b1;
      if (enable)
        pwm_cnt <= (pwm_cnt >= PWM_MAX) ? '0 : pwm_cnt + 1'b1;
      if (load) begin
        snap_data <= data;
        snap_dp   <= dp;
        snap_lz   <= blank_lz;
        loaded    <= 1'b1;
      end
    end
  end

  logic [DIGITS-1:0] lz_mask;
  logic              zero_run;

  // Scan from the top digit down; blanking stops at the first nonzero.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run   = zero_run && (snap_data[4*i +: 4] == 4'h0);
      lz_mask[i] = snap_lz && zero_run;
    end
  end

  logic [3:0]        nib;
  logic              dp_sel;
  logic              blank;
  logic [DIGITS-1:0] onehot;
  logic              lit;
  logic [DIGITS-1:0] an_nx;
  logic [6:0]        seg_nx;
  logic              dp_nx;

  // count==0 is the first cycle of a slot: anode held off there.
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    blank  = 1'b0;
    onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib       = snap_data[4*i +: 4];
        dp_sel    = snap_dp[i];
        blank     = lz_mask[i];
        onehot[i] = 1'b1;
      end
    end
    lit    = enable && (count != '0) && (pwm_cnt < brightness);
    an_nx  = lit ? onehot : '0;
    seg_nx = (enable && !blank) ? nibble_to_seg(nib) : SEG_BLANK;
    dp_nx  = enable && dp_sel;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      anodes     <= AN_INV;
      segments   <= SEG_INV;
      seg_dp     <= SEG_POL;
      frame_tick <= 1'b0;
    end else begin
      anodes     <= an_nx ^ AN_INV;
      segments   <= seg_nx ^ SEG_INV;
      seg_dp     <= dp_nx ^ SEG_POL;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux: scan, snapshot,
// zero blanking, enable freeze, reset, PWM, polarity.
module tb_hex_display_mux;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = '0;

  logic [3:0] an0, an1, an2;
  logic [6:0] seg0, seg1, seg2, seg3;
  logic       sdp0, sdp1, sdp2, sdp3;
  logic       ft0, ft1, ft2, ft3;
  logic       an3;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 CLK = ~CLK;

  hex_display_mux #(.DIGITS(4), .DIV(4), .BRIGHT_W(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u0 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .data(data),
    .dp(dp), .blank_lz(blank_lz), .brightness(brightness),
    .anodes(an0), .segments(seg0), .seg_dp(sdp0),
    .frame_tick(ft0));

  hex_display_mux #(.DIGITS(4), .DIV(4), .BRIGHT_W(2),
    .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)) u1 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .data(data),
    .dp(dp), .blank_lz(blank_lz), .brightness(brightness),
    .anodes(an1), .segments(seg1), .seg_dp(sdp1),
    .frame_tick(ft1));

  hex_display_mux #(.DIGITS(4), .DIV(16), .BRIGHT_W(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u2 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .data(data),
    .dp(dp), .blank_lz(blank_lz), .brightness(brightness),
    .anodes(an2), .segments(seg2), .seg_dp(sdp2),
    .frame_tick(ft2));

  hex_display_mux #(.DIGITS(1), .DIV(4), .BRIGHT_W(2),
    .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)) u3 (
    .CLK(CLK), .RST_N(RST_N), .enable(enable),
    .data(data[3:0]), .dp(dp[0:0]), .blank_lz(blank_lz),
    .brightness(brightness), .anodes(an3), .segments(seg3),
    .seg_dp(sdp3), .frame_tick(ft3));

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s @cyc %0d: observed %h expected %h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    logic [6:0] scan_seg [4];
    int         lit_exp [4];
    int         d;
    int         lit_cnt;
    logic [3:0] ea;
    logic [1:0] b;

    scan_seg = '{7'h4C, 7'h06, 7'h12, 7'h4F};
    lit_exp  = '{0, 5, 10, 15};

    step();
    step();
    check("rst_an", an0, 4'hF);
    check("rst_seg", seg0, 7'h7F);
    check("rst_dp", sdp0, 1'b1);
    check("rst_ft", ft0, 1'b0);
    check("rst_an_hi", an1, 4'h0);
    check("rst_seg_hi", seg1, 7'h00);
    check("rst_dp_hi", sdp1, 1'b0);

    data = 16'h1234;
    brightness = 2'd3;
    enable = 1'b1;
    RST_N = 1'b1;
    cyc = 0;

    for (int k = 1; k <= 17; k++) begin
      step();
      if (k >= 2) begin
        d  = ((k - 1) / 4) % 4;
        ea = ((k - 1) % 4 == 0) ? 4'hF : ~(4'b0001 << d);
        check("scan_an", an0, ea);
        check("scan_seg", seg0, scan_seg[d]);
        check("scan_dp", sdp0, 1'b1);
        check("d1_ft", ft3, (k % 4) == 0);
      end
      if (k >= 15)
        check("scan_ft", ft0, k == 16);
      if (k == 2) begin
        check("pol_an", an1, 4'b0001);
        check("pol_seg", seg1, 7'h33);
        check("d1_an", an3, 1'b0);
        check("d1_seg", seg3, 7'h4C);
      end
    end

    data = 16'h0005;
    blank_lz = 1'b1;
    dp = 4'b0100;

    run_to(18);
    check("old_an", an0, 4'hE);
    check("old_seg", seg0, 7'h4C);
    run_to(30);
    check("old_d3", seg0, 7'h4F);
    check("old_ft", ft0, 1'b0);
    run_to(32);
    check("frame_ft", ft0, 1'b1);

    run_to(34);
    check("lz0_an", an0, 4'hE);
    check("lz0_seg", seg0, 7'h24);
    check("lz0_dp", sdp0, 1'b1);
    run_to(38);
    check("lz1_an", an0, 4'hD);
    check("lz1_seg", seg0, 7'h7F);
    check("lz1_dp", sdp0, 1'b1);
    data = 16'hABCD;
    run_to(42);
    check("lz2_an", an0, 4'hB);
    check("lz2_seg", seg0, 7'h7F);
    check("lz2_dp", sdp0, 1'b0);
    run_to(44);
    check("lz2_hold", seg0, 7'h7F);
    run_to(46);
    check("lz3_an", an0, 4'h7);
    check("lz3_seg", seg0, 7'h7F);
    check("lz3_dp", sdp0, 1'b1);
    run_to(50);
    check("new_an", an0, 4'hE);
    check("new_seg", seg0, 7'h42);

    run_to(52);
    enable = 1'b0;
    for (int k = 53; k <= 62; k++) begin
      step();
      check("off_an", an0, 4'hF);
      check("off_seg", seg0, 7'h7F);
      check("off_ft", ft0, 1'b0);
      check("off_ft1", ft3, 1'b0);
    end
    enable = 1'b1;
    run_to(63);
    check("resume_guard", an0, 4'hF);
    check("resume_seg", seg0, 7'h31);
    run_to(64);
    check("resume_an", an0, 4'hD);
    check("resume_seg2", seg0, 7'h31);
    run_to(73);
    check("shift_ft0", ft0, 1'b0);
    run_to(74);
    check("shift_ft1", ft0, 1'b1);

    run_to(76);
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_an", an0, 4'hF);
    check("mid_rst_seg", seg0, 7'h7F);
    check("mid_rst_dp", sdp0, 1'b1);
    check("mid_rst_ft", ft0, 1'b0);
    check("mid_rst_an_hi", an1, 4'h0);
    check("mid_rst_seg_hi", seg1, 7'h00);

    for (int j = 0; j < 4; j++) begin
      b = 2'(j);
      step();
      RST_N = 1'b0;
      brightness = b;
      #2;
      RST_N = 1'b1;
      lit_cnt = 0;
      for (int k = 1; k <= 16; k++) begin
        step();
        if (k == 1)
          check("pwm_guard", an2, 4'hF);
        else if (an2 == 4'hE)
          lit_cnt++;
      end
      check("pwm_lit", 16'(lit_cnt), 16'(lit_exp[j]));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_display_mux.md
Name: hex_display_mux

Overview:
- Parametrised multiplexed seven-segment driver; next generation of the fixed 4-digit hex display driver.
- Drives N common-anode/cathode digits from a packed hex word, with an internal refresh divider, per-digit decimal points, leading-zero suppression, PWM brightness and output polarity selection.
- Sits between the design's data word and board pins `DS_EN*` / `DS_A..DS_G`. Replaces the external clock divider + `hex_display` pair in top-level wrappers.

Parameters:
- `DIGITS`, 4: number of multiplexed digits (1..16).
- `DIV`, 50000: `CLK` cycles per digit slot (>= 2).
- `BRIGHT_W`, 4: brightness control width.
- `ANODE_ACTIVE_LOW`, 1: 1 inverts `anodes` at the output (pin-level active-low).
- `SEG_ACTIVE_LOW`, 1: 1 inverts `segments` and `seg_dp` at the output.

Ports:
- `CLK` in 1: system clock.
- `RST_N` in 1: asynchronous active-low reset.
- `enable` in 1: 0 blanks the display and freezes the scan.
- `data` in 4*DIGITS: hex nibbles; `data[3:0]` = digit 0 (rightmost).
- `dp` in DIGITS: decimal point per digit; bit i = digit i.
- `blank_lz` in 1: 1 enables leading-zero suppression.
- `brightness` in BRIGHT_W: duty control; 0 = off, all-ones = full on.
- `anodes` out DIGITS: digit enables, one-hot when lit; bit i = digit i.
- `segments` out 7: `{a,b,c,d,e,f,g}`.
- `seg_dp` out 1: decimal point segment.
- `frame_tick` out 1: one-cycle pulse when digit DIGITS-1 finishes its slot.

Behaviour:
- **Reset** (`RST_N`=0, async): prescaler=0, digit index=0, PWM counter=0, snapshot=0. `anodes`, `segments`, `seg_dp` are all at the inactive level (all-ones when the matching ACTIVE_LOW=1). `frame_tick`=0. Release is synchronous to the next `CLK` edge.
- **Prescaler**: counts 0..DIV-1; `slot_end` is asserted when count==DIV-1, then wraps to 0.
- **Digit index**: advances on `slot_end`, wrapping DIGITS-1 -> 0. `frame_tick` is registered high for exactly the cycle after a `slot_end` with index==DIGITS-1.
- **Snapshot**: `data`, `dp` and `blank_lz` are captured into the snapshot register on `slot_end` when index==DIGITS-1, and once on the first enabled cycle after reset. This avoids mid-frame tearing. Input changes appear only from the next frame.
- **Decode**: nibble 0-F maps to standard hex glyphs (b and d lowercase), held in a package lookup.
- **Leading-zero suppression**: with snapshot `blank_lz`=1, digit i>0 is blanked (segments off) iff snapshot nibbles DIGITS-1..i are all zero. Digit 0 is never suppressed. `dp` is still shown on suppressed digits.
- **PWM**: counter runs 0..2^BRIGHT_W-2 and wraps, free-running each `CLK`. The active anode is lit only when pwm_cnt < `brightness`, so `brightness`=2^BRIGHT_W-1 gives 100% duty. `brightness` is sampled live, not snapshotted.
- **Ghost guard**: the anode is forced inactive during the first cycle of every slot (cycle after `slot_end`). Segments change in that same cycle.
- **Output timing**: all outputs are registered. Latency from an index/PWM change to the pins is 1 `CLK`.
- **Polarity**: the internal active-high anode and segment vectors are XOR-inverted per parameter at the output register.
- **enable=0**:
  - prescaler, index and PWM hold;
  - outputs go inactive on the next cycle;
  - `frame_tick`=0.
  - On `enable`=1, scanning resumes from the held state.
- **DIGITS=1**: index is constant 0, and `frame_tick` fires every `slot_end`.
- **Reset mid-frame**: immediate return to reset values. The snapshot is reloaded on the first enabled cycle after reset.

Decomposition:
- **Package `hex_display_pkg`**:
  - 16-entry 7-bit glyph constant table;
  - `SEG_BLANK` constant;
  - function `nibble_to_seg`.
- **Sub-module `refresh_divider`**: parametrised on `DIV`, provides prescaler counter and `slot_end`, with `CLK`/`RST_N`/`enable` inputs.
- All other logic (index, snapshot, LZ mask, PWM, output regs) lives in `hex_display_mux`.

Test Plan (`DIGITS`=4, `DIV`=4, `BRIGHT_W`=2, both ACTIVE_LOW=1 unless noted):
- **Reset**: assert `RST_N`=0 mid-slot -> within 0 cycles `anodes`=4'b1111, `segments`=7'h7F, `seg_dp`=1, `frame_tick`=0. Release -> first lit slot shows digit 0.
- **Scan**: `data`=16'h1234, `brightness`=3 -> slots cycle digit 0..3 with glyphs 4,3,2,1. `anodes` go 1110, 1101, 1011, 0111, each lit 3 of 4 cycles (guard cycle off). `frame_tick` pulses every 16 cycles.
- **Snapshot/LZ**: `data`=16'h0005 + `blank_lz`=1 + `dp`=4'b0100 -> digits 3 blank, digit 2 blank with `seg_dp`=0 (active), digit 1 blank, digit 0 shows "5". Changing `data` to 16'hABCD mid-frame takes effect only after the next `frame_tick`.
- **Brightness**: hold a slot with `DIV`=16. `brightness`=0 -> `anodes` never active. 1 -> active 1 of every 3 non-guard cycles. 3 -> active every non-guard cycle.
- **Enable/polarity**: `enable`=0 for 10 cycles -> outputs inactive, index unchanged, no `frame_tick`. Re-enable resumes the same digit. Rerun with ANODE_ACTIVE_LOW=0 / SEG_ACTIVE_LOW=0 -> reset `anodes`=0000, `segments`=0, lit anode one-hot high.
